// File: rtl/sync_reg_arb_pkg.sv
// Shared types and constants for the SyncRegister source-side arbiter.
package sync_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } arb_state_t;

  localparam int unsigned CNT_W = 16;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, searching cyclically.
module rr_pick
  import sync_reg_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] pos;

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = ptr;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
      pos = (pos == IDW'(N - 1)) ? '0 : pos + IDW'(1);
    end
  end

endmodule

// File: rtl/sync_reg_arbiter.sv
// Round-robin source-domain front end for a shared SyncRegister crossing:
// grants one requester, pulses sync_en once, then waits for sync_rdy to fall and recover.
module sync_reg_arbiter
  import sync_reg_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ack,
  output logic                    sync_en,
  input  logic                    sync_rdy,
  output logic [WIDTH-1:0]        sync_data,
  output logic [id_w(NREQ)-1:0]   grant_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        xfer_count,
  output logic                    err,
  input  logic                    err_clr
);

  localparam int unsigned IDW = id_w(NREQ);

  arb_state_t       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win_idx;
  logic             win_any;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] hold;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] tcnt_nxt;
  logic             to_hit;

  rr_pick #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (win_any),
    .idx (win_idx)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // One-shot timeout strobe: fires only on the cycle the counter steps onto TIMEOUT,
  // so a clear issued afterwards is not immediately overridden while still waiting.
  always_comb begin
    tcnt_nxt = (tcnt == '1) ? tcnt : tcnt + 1'b1;
    to_hit   = ((state == WAIT_LO) || (state == WAIT_HI)) &&
               (tcnt != '1) && (tcnt_nxt == CNT_W'(TIMEOUT));
  end

  assign sync_data = hold;
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      hold       <= '0;
      grant_id   <= '0;
      xfer_count <= '0;
      err        <= 1'b0;
      tcnt       <= '0;
      sync_en    <= 1'b0;
      req_ack    <= '0;
    end else begin
      sync_en <= 1'b0;
      req_ack <= '0;

      if (to_hit)       err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      case (state)
        IDLE: begin
          if (sync_rdy && win_any) begin
            hold     <= win_data;
            grant_id <= win_idx;
            sync_en  <= 1'b1;
            req_ack  <= NREQ'(1) << win_idx;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
          tcnt   <= '0;
          state  <= WAIT_LO;
        end
        WAIT_LO: begin
          tcnt <= tcnt_nxt;
          if (!sync_rdy) state <= WAIT_HI;
        end
        WAIT_HI: begin
          tcnt <= tcnt_nxt;
          if (sync_rdy) begin
            xfer_count <= xfer_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_reg_arbiter.sv
// Directed bench for sync_reg_arbiter with a simple SyncRegister sRDY model.
module tb_sync_reg_arbiter;
  import sync_reg_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ack;
  logic         sync_en;
  logic         sync_rdy;
  logic [31:0]  sync_data;
  logic [1:0]   grant_id;
  logic         busy;
  logic [15:0]  xfer_count;
  logic         err;
  logic         err_clr;

  logic         auto_mode;
  logic         rdy_man;
  logic         rdy_model;
  int unsigned  rec_cnt;
  int unsigned  hs_phase;
  int unsigned  hs_viol = 0;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] dword [4];
  int unsigned order [6];
  logic        saw;

  always #5 clk = ~clk;

  assign sync_rdy = auto_mode ? rdy_model : rdy_man;

  sync_reg_arbiter #(
    .NREQ    (4),
    .WIDTH   (32),
    .TIMEOUT (10)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .sync_en    (sync_en),
    .sync_rdy   (sync_rdy),
    .sync_data  (sync_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .xfer_count (xfer_count),
    .err        (err),
    .err_clr    (err_clr)
  );

  // Crossing model: sRDY drops the cycle after sEN and stays low for 6 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_model <= 1'b1;
      rec_cnt   <= 0;
    end else if (sync_en) begin
      rdy_model <= 1'b0;
      rec_cnt   <= 6;
    end else if (rec_cnt != 0) begin
      rec_cnt <= rec_cnt - 1;
      if (rec_cnt == 1) rdy_model <= 1'b1;
    end
  end

  // Handshake watcher: each sync_en needs sync_rdy high and a full low/high since the last one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_phase <= 0;
    end else if (sync_en) begin
      if (hs_phase != 0 || !sync_rdy) hs_viol <= hs_viol + 1;
      hs_phase <= 1;
    end else if (hs_phase == 1 && !sync_rdy) begin
      hs_phase <= 2;
    end else if (hs_phase == 2 && sync_rdy) begin
      hs_phase <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input string tag, input bit for_ack);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      hit = for_ack ? (req_ack != '0) : !busy;
    end
    chk({tag, "_wait"}, 64'(hit), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dword[0] = 32'hDEAD_0000;
    dword[1] = 32'hBEEF_0001;
    dword[2] = 32'hCAFE_0002;
    dword[3] = 32'hF00D_0003;
    order[0] = 0; order[1] = 1; order[2] = 2;
    order[3] = 3; order[4] = 0; order[5] = 1;

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    err_clr   = 1'b0;
    auto_mode = 1'b1;
    rdy_man   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sync_en",   64'(sync_en),    64'd0);
    chk("rst_req_ack",   64'(req_ack),    64'd0);
    chk("rst_busy",      64'(busy),       64'd0);
    chk("rst_grant_id",  64'(grant_id),   64'd0);
    chk("rst_sync_data", 64'(sync_data),  64'd0);
    chk("rst_xfer",      64'(xfer_count), 64'd0);
    chk("rst_err",       64'(err),        64'd0);
    rst_n = 1'b1;

    // Fairness: all four held valid, expect 0,1,2,3,0,1
    @(negedge clk);
    req_data  = {dword[3], dword[2], dword[1], dword[0]};
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_until("fair_ack", 1'b1);
      chk("fair_grant_id", 64'(grant_id),  64'(order[k]));
      chk("fair_req_ack",  64'(req_ack),   64'(4'b0001 << order[k]));
      chk("fair_data",     64'(sync_data), 64'(dword[order[k]]));
      chk("fair_sync_en",  64'(sync_en),   64'd1);
    end
    req_valid = '0;
    wait_until("fair_idle", 1'b0);
    chk("fair_xfer", 64'(xfer_count), 64'd6);
    chk("fair_hs",   64'(hs_viol),    64'd0);

    // Single requester, exact T+1 / T+2 timing
    @(negedge clk);
    req_data[31:0] = 32'hA5A5_A5A5;
    req_valid      = 4'b0001;
    chk("single_pre_en", 64'(sync_en), 64'd0);
    @(negedge clk);
    chk("single_en",      64'(sync_en),   64'd1);
    chk("single_ack",     64'(req_ack),   64'h1);
    chk("single_data",    64'(sync_data), 64'hA5A5_A5A5);
    chk("single_busy",    64'(busy),      64'd1);
    req_valid = '0;
    @(negedge clk);
    chk("single_en_off",  64'(sync_en),  64'd0);
    chk("single_ack_off", 64'(req_ack),  64'h0);
    chk("single_rdy_lo",  64'(sync_rdy), 64'd0);
    wait_until("single_idle", 1'b0);
    chk("single_xfer",      64'(xfer_count), 64'd7);
    chk("single_data_hold", 64'(sync_data),  64'hA5A5_A5A5);

    // Not ready: no grant while sync_rdy is low
    auto_mode = 1'b0;
    rdy_man   = 1'b0;
    req_valid = 4'b0100;
    saw       = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw = saw | sync_en | busy | (|req_ack);
    end
    chk("nrdy_quiet", 64'(saw), 64'd0);
    rdy_man = 1'b1;
    @(negedge clk);
    chk("nrdy_en",       64'(sync_en),   64'd1);
    chk("nrdy_grant_id", 64'(grant_id),  64'd2);
    chk("nrdy_ack",      64'(req_ack),   64'h4);
    chk("nrdy_data",     64'(sync_data), 64'(dword[2]));
    req_valid = '0;

    // Timeout with sync_rdy stuck low; set beats a simultaneous clear
    @(negedge clk);
    rdy_man = 1'b0;
    chk("to_busy", 64'(busy), 64'd1);
    repeat (9) @(negedge clk);
    chk("to_err_before", 64'(err), 64'd0);
    err_clr = 1'b1;
    @(negedge clk);
    chk("to_err_set_wins", 64'(err), 64'd1);
    @(negedge clk);
    chk("to_err_cleared", 64'(err),  64'd0);
    chk("to_still_busy",  64'(busy), 64'd1);
    err_clr = 1'b0;
    rdy_man = 1'b1;
    @(negedge clk);
    chk("to_idle",     64'(busy),       64'd0);
    chk("to_xfer",     64'(xfer_count), 64'd8);
    chk("to_err_stay", 64'(err),        64'd0);
    auto_mode = 1'b1;

    // Reset during WAIT_HI
    @(negedge clk);
    req_valid = 4'b0100;
    wait_until("mid_ack", 1'b1);
    chk("mid_grant_id", 64'(grant_id), 64'd2);
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("mid_state", 64'(dut.state), 64'(WAIT_HI));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",     64'(busy),       64'd0);
    chk("mid_rst_en",       64'(sync_en),    64'd0);
    chk("mid_rst_ack",      64'(req_ack),    64'd0);
    chk("mid_rst_grant",    64'(grant_id),   64'd0);
    chk("mid_rst_data",     64'(sync_data),  64'd0);
    chk("mid_rst_xfer",     64'(xfer_count), 64'd0);
    chk("mid_rst_err",      64'(err),        64'd0);
    chk("mid_rst_rr_ptr",   64'(dut.rr_ptr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_data[63:32] = 32'h1234_5678;
    req_valid       = 4'b0010;
    wait_until("post_ack", 1'b1);
    chk("post_grant_id", 64'(grant_id),  64'd1);
    chk("post_ack_vec",  64'(req_ack),   64'h2);
    chk("post_data",     64'(sync_data), 64'h1234_5678);
    req_valid = '0;
    wait_until("post_idle", 1'b0);
    chk("post_xfer", 64'(xfer_count), 64'd1);

    // Counter wrap
    @(negedge clk);
    force dut.xfer_count = 16'hFFFF;
    #1;
    chk("wrap_preload", 64'(xfer_count), 64'hFFFF);
    release dut.xfer_count;
    req_valid = 4'b0001;
    wait_until("wrap_ack", 1'b1);
    req_valid = '0;
    wait_until("wrap_idle", 1'b0);
    chk("wrap_xfer", 64'(xfer_count), 64'd0);

    chk("hs_rules", 64'(hs_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
